// File: rtl/collision_probe.sv
// Free-running 9-cycle sweep: probes 8 hitbox-edge points through a 1-cycle tile ROM
// and publishes {up, down, left, right} solidity flags atomically once per sweep.
module collision_probe #(
  parameter int CHAR_W     = 20,
  parameter int CHAR_H     = 20,
  parameter int TILE_SHIFT = 5,
  parameter int MAP_W      = 25,
  parameter int MAP_H      = 19,
  parameter int ADDR_W     = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  output logic [ADDR_W-1:0] map_addr,
  input  logic              map_data,
  output logic [3:0]        is_collide,
  output logic              sweep_done
);

  typedef enum logic {S_PROBE, S_LAST} state_t;

  localparam logic signed [10:0] W_S   = 11'(CHAR_W);
  localparam logic signed [10:0] H_S   = 11'(CHAR_H);
  localparam logic signed [10:0] X_LIM = 11'(MAP_W << TILE_SHIFT);
  localparam logic signed [10:0] Y_LIM = 11'(MAP_H << TILE_SHIFT);

  // Returns {out_of_map, tile_address} for probe k of a hitbox at (x, y).
  function automatic logic [ADDR_W:0] probe(input logic [2:0] k,
                                            input logic [9:0] x,
                                            input logic [9:0] y);
    logic signed [10:0] bx, by, px, py;
    logic [10:0]        ux, uy;
    logic               oob;
    bx = signed'({1'b0, x});
    by = signed'({1'b0, y});
    case (k)
      3'd0:    begin px = bx;           py = by - 11'sd1;       end
      3'd1:    begin px = bx + W_S - 1; py = by - 11'sd1;       end
      3'd2:    begin px = bx;           py = by + H_S;          end
      3'd3:    begin px = bx + W_S - 1; py = by + H_S;          end
      3'd4:    begin px = bx - 11'sd1;  py = by;                end
      3'd5:    begin px = bx - 11'sd1;  py = by + H_S - 1;      end
      3'd6:    begin px = bx + W_S;     py = by;                end
      default: begin px = bx + W_S;     py = by + H_S - 1;      end
    endcase
    oob = (px < 0) || (py < 0) || (px >= X_LIM) || (py >= Y_LIM);
    ux  = px;
    uy  = py;
    if (oob)
      probe = {1'b1, {ADDR_W{1'b0}}};
    else
      probe = {1'b0, ADDR_W'((uy >> TILE_SHIFT) * MAP_W + (ux >> TILE_SHIFT))};
  endfunction

  state_t      state;
  logic [2:0]  k;
  logic        primed;
  logic [9:0]  lat_x, lat_y;
  logic [3:0]  acc;
  logic        oob_q, oob_d1;

  logic        issue_k0;
  logic [9:0]  src_x, src_y;
  logic [2:0]  next_k;
  logic [ADDR_W:0] nxt;
  logic [2:0]  done_k;
  logic [3:0]  hit_vec;

  always_comb begin
    issue_k0 = !primed || (state == S_LAST);
    src_x    = issue_k0 ? pos_x : lat_x;
    src_y    = issue_k0 ? pos_y : lat_y;
    next_k   = issue_k0 ? 3'd0 : 3'(k + 3'd1);
    nxt      = probe(next_k, src_x, src_y);
    // Data arriving now belongs to the probe issued one cycle earlier.
    done_k   = (state == S_LAST) ? 3'd7 : 3'(k - 3'd1);
    hit_vec  = (map_data || oob_d1) ? (4'b1000 >> done_k[2:1]) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_PROBE;
      k          <= 3'd0;
      primed     <= 1'b0;
      lat_x      <= '0;
      lat_y      <= '0;
      acc        <= 4'b0000;
      oob_q      <= 1'b0;
      oob_d1     <= 1'b0;
      map_addr   <= '0;
      is_collide <= 4'b0000;
      sweep_done <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      oob_d1     <= oob_q;
      if (!primed) begin
        primed   <= 1'b1;
        lat_x    <= pos_x;
        lat_y    <= pos_y;
        map_addr <= nxt[ADDR_W-1:0];
        oob_q    <= nxt[ADDR_W];
      end else begin
        case (state)
          S_PROBE: begin
            if (k != 3'd0) acc <= acc | hit_vec;
            if (k == 3'd7) begin
              state    <= S_LAST;
              map_addr <= '0;
              oob_q    <= 1'b0;
            end else begin
              k        <= next_k;
              map_addr <= nxt[ADDR_W-1:0];
              oob_q    <= nxt[ADDR_W];
            end
          end
          default: begin
            is_collide <= acc | hit_vec;
            sweep_done <= 1'b1;
            acc        <= 4'b0000;
            state      <= S_PROBE;
            k          <= 3'd0;
            lat_x      <= pos_x;
            lat_y      <= pos_y;
            map_addr   <= nxt[ADDR_W-1:0];
            oob_q      <= nxt[ADDR_W];
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_collision_probe.sv
// Directed bench for collision_probe with a behavioural 1-cycle tile ROM.
module tb_collision_probe;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] pos_x, pos_y;
  logic [8:0] map_addr;
  logic       map_data = 1'b0;
  logic [3:0] is_collide;
  logic       sweep_done;
  int         mode;   // 0 empty, 1 row 18 solid, 2 only tile (7,10) solid
  int         vectors = 0;
  int         errors  = 0;
  int         n;

  collision_probe dut (
    .clk(clk), .rst(rst), .pos_x(pos_x), .pos_y(pos_y),
    .map_addr(map_addr), .map_data(map_data),
    .is_collide(is_collide), .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  function automatic logic solid(input logic [8:0] a, input int m);
    case (m)
      1:       return (a >= 9'd450) && (a < 9'd475);
      2:       return a == 9'd257;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) map_data <= solid(map_addr, mode);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pub(output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!sweep_done && cnt < 40);
    chk("publish_seen", 32'(sweep_done), 32'd1);
  endtask

  task automatic settle(input logic [9:0] x, input logic [9:0] y, input int m,
                        input logic [3:0] exp, input string tag);
    int c;
    pos_x = x;
    pos_y = y;
    mode  = m;
    wait_pub(c);
    wait_pub(c);
    chk(tag, 32'(is_collide), 32'(exp));
    chk({tag, "_period"}, 32'(c), 32'd9);
  endtask

  logic [8:0] exp_addr [8];

  initial begin
    exp_addr = '{9'd431, 9'd431, 9'd456, 9'd456, 9'd431, 9'd431, 9'd431, 9'd431};
    rst = 1'b1; mode = 1; pos_x = 10'd200; pos_y = 10'd556;
    repeat (2) step();
    chk("rst_collide", 32'(is_collide), 32'd0);
    chk("rst_done",    32'(sweep_done), 32'd0);
    chk("rst_addr",    32'(map_addr),   32'd0);

    rst = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("addr_k%0d", i), 32'(map_addr), 32'(exp_addr[i]));
      if (i < 7) step();
    end
    step();
    chk("first_done_early", 32'(sweep_done), 32'd0);
    step();
    chk("first_done",    32'(sweep_done), 32'd1);
    chk("first_collide", 32'(is_collide), 32'd4);
    step();
    chk("done_one_cycle", 32'(sweep_done), 32'd0);
    chk("collide_hold",   32'(is_collide), 32'd4);
    wait_pub(n);
    chk("repeat_gap", 32'(n), 32'd8);
    chk("repeat_collide", 32'(is_collide), 32'd4);

    settle(10'd0,   10'd100, 0, 4'b0010, "left_edge");
    settle(10'd0,   10'd0,   0, 4'b1010, "top_left_corner");
    settle(10'd204, 10'd320, 2, 4'b0001, "tile_right");
    settle(10'd203, 10'd320, 2, 4'b0000, "tile_miss");
    settle(10'd780, 10'd200, 0, 4'b0001, "right_edge");
    settle(10'd100, 10'd588, 0, 4'b0100, "bottom_edge");

    settle(10'd200, 10'd556, 1, 4'b0100, "ground");
    repeat (3) step();
    pos_x = 10'd204; pos_y = 10'd320;
    wait_pub(n);
    chk("midsweep_old",     32'(is_collide), 32'd4);
    chk("midsweep_old_gap", 32'(n), 32'd6);
    wait_pub(n);
    chk("midsweep_new",     32'(is_collide), 32'd0);

    settle(10'd200, 10'd556, 1, 4'b0100, "ground_again");
    repeat (4) step();
    rst = 1'b1;
    step();
    chk("midrst_collide", 32'(is_collide), 32'd0);
    chk("midrst_done",    32'(sweep_done), 32'd0);
    chk("midrst_addr",    32'(map_addr),   32'd0);
    rst = 1'b0; pos_x = 10'd204; pos_y = 10'd320;
    step();
    chk("postrst_k0_addr", 32'(map_addr), 32'd231);
    wait_pub(n);
    chk("postrst_gap",     32'(n), 32'd9);
    chk("postrst_collide", 32'(is_collide), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
